// File: rtl/vga_cmd_pkg.sv
// Shared types and widths for the VGA command sink.
//
// Purpose: command class encoding, the packed queue entry, FSM state
// encoding and the display field widths used by vga_cmd_fifo and
// vga_cmd_sink.
//
// Ports: none (package).
package vga_cmd_pkg;

  localparam int COORD_W     = 10;
  localparam int ATTR_W      = 16;
  localparam int COLOR_W     = 12;
  localparam int FONT_ADDR_W = 12;
  localparam int FONT_DATA_W = 8;
  localparam int SRCA_W      = 12;

  typedef enum logic [1:0] {
    CMD_SPRITE = 2'd0,
    CMD_FONT   = 2'd1,
    CMD_BG     = 2'd2
  } cmd_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } sink_state_e;

  // srcbHi carries operand B [25:16] (sprite y); srcbLo carries [15:0].
  typedef struct packed {
    cmd_class_e         cls;
    logic               selPos;
    logic               selAttr;
    logic               selVisi;
    logic [SRCA_W-1:0]  srca;
    logic [COORD_W-1:0] srcbHi;
    logic [ATTR_W-1:0]  srcbLo;
  } cmd_entry_t;

  // Collapses the class strobes into one class. Sprite wins over font,
  // font over background, if the core ever raises more than one.
  function automatic cmd_class_e classOf(input logic isSprite, input logic isFont);
    if (isSprite) begin
      return CMD_SPRITE;
    end else if (isFont) begin
      return CMD_FONT;
    end
    return CMD_BG;
  endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO for the VGA command sink.
//
// Purpose: stores queued display commands in strict arrival order.
// Pointers wrap modulo DEPTH (a power of two); count is one bit wider
// than the pointers so "full" and "empty" are unambiguous.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   push_i      enqueue data_i (ignored while full)
//   data_i      entry to enqueue
//   pop_i       dequeue the head entry (ignored while empty)
//   data_o      head entry, valid while not empty
//   full_o      count == DEPTH
//   empty_o     count == 0
//   count_o     number of stored entries
module vga_cmd_fifo
  import vga_cmd_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cmd_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  // A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vga_cmd_sink.sv
// VGA command sink: display-side receiver for the core's VGA instructions.
//
// Purpose: captures sprite/font/background commands from the E stage,
// queues them, and commits them one per cycle to the live display
// attribute registers. Back-pressures the core through vga_stall when
// the queue is full.
//
// Configuration macro: VGA_TEAR_GUARD_EN
//   defined   - commits only happen while vblank is high; a drain that
//               is cut short by vblank falling resumes at the next vblank.
//   undefined - vblank is ignored; entries commit whenever queued.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   spriteE, fontE, backgroundE    command class strobes
//   posE, attrE, visiE             sprite field selects (combinable)
//   stallE                         E stage held, strobes ignored
//   srcaE                          sprite index [2:0] / font address [11:0]
//   srcbE                          payload
//   vblank                         vertical blank level
//   vga_stall                      queue full
//   spr_x, spr_y, spr_attr, spr_vis  flattened sprite registers, sprite 0 in LSBs
//   bg_color                       background RGB444
//   font_we, font_addr, font_data  one-cycle font RAM write
//   frame_commit                   pulse when the queue drains to empty
module vga_cmd_sink
  import vga_cmd_pkg::*;
#(
  parameter int NSPRITE = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       spriteE,
  input  logic                       fontE,
  input  logic                       backgroundE,
  input  logic                       posE,
  input  logic                       attrE,
  input  logic                       visiE,
  input  logic                       stallE,
  input  logic [31:0]                srcaE,
  input  logic [31:0]                srcbE,
  input  logic                       vblank,
  output logic                       vga_stall,
  output logic [NSPRITE*COORD_W-1:0] spr_x,
  output logic [NSPRITE*COORD_W-1:0] spr_y,
  output logic [NSPRITE*ATTR_W-1:0]  spr_attr,
  output logic [NSPRITE-1:0]         spr_vis,
  output logic [COLOR_W-1:0]         bg_color,
  output logic                       font_we,
  output logic [FONT_ADDR_W-1:0]     font_addr,
  output logic [FONT_DATA_W-1:0]     font_data,
  output logic                       frame_commit
);

  localparam int IDXW = (NSPRITE > 1) ? $clog2(NSPRITE) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;

  sink_state_e                state_q;
  logic                       frameCommit_q;
  logic [NSPRITE*COORD_W-1:0] sprX_q;
  logic [NSPRITE*COORD_W-1:0] sprY_q;
  logic [NSPRITE*ATTR_W-1:0]  sprAttr_q;
  logic [NSPRITE-1:0]         sprVis_q;
  logic [COLOR_W-1:0]         bgColor_q;
  logic                       fontWe_q;
  logic [FONT_ADDR_W-1:0]     fontAddr_q;
  logic [FONT_DATA_W-1:0]     fontData_q;

  cmd_entry_t    pushEntry;
  cmd_entry_t    headEntry;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic          cmdStrobe;
  logic          pushEn;
  logic          popEn;
  logic          lastPop;
  logic          commitWindow;
  logic [IDXW-1:0] sprIdx;

  // Operand bits the sink never looks at.
  logic unusedOperandBits;

`ifdef VGA_TEAR_GUARD_EN
  localparam sink_state_e ARM_STATE = ST_WAIT;
  assign commitWindow      = vblank;
  assign unusedOperandBits = ^{srcaE[31:SRCA_W], srcbE[31:26], fifoFull};
`else
  localparam sink_state_e ARM_STATE = ST_DRAIN;
  assign commitWindow      = 1'b1;
  assign unusedOperandBits = ^{srcaE[31:SRCA_W], srcbE[31:26], fifoFull, vblank};
`endif

  assign cmdStrobe = spriteE | fontE | backgroundE;
  assign vga_stall = (fifoCount == CW'(DEPTH));
  assign pushEn    = cmdStrobe & ~stallE & ~vga_stall;

  // The head entry commits on the same edge that WAIT sees the commit
  // window open, so a push into an empty queue during vblank lands one
  // edge later.
  assign popEn   = (state_q != ST_IDLE) & ~fifoEmpty & commitWindow;
  // A push alongside the final pop keeps the queue non-empty.
  assign lastPop = popEn & (fifoCount == CW'(1)) & ~pushEn;
  assign sprIdx  = headEntry.srca[IDXW-1:0];

  always_comb begin
    pushEntry         = '0;
    pushEntry.cls     = classOf(spriteE, fontE);
    pushEntry.selPos  = posE;
    pushEntry.selAttr = attrE;
    pushEntry.selVisi = visiE;
    pushEntry.srca    = srcaE[SRCA_W-1:0];
    pushEntry.srcbHi  = srcbE[25:16];
    pushEntry.srcbLo  = srcbE[15:0];
  end

  vga_cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cmd_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushEn),
    .data_i  (pushEntry),
    .pop_i   (popEn),
    .data_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Sequencing FSM with the registered frame_commit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frameCommit_q <= 1'b0;
    end else begin
      frameCommit_q <= lastPop;
      unique case (state_q)
        ST_IDLE: begin
          if (pushEn) begin
            state_q <= ARM_STATE;
          end
        end
        ST_WAIT: begin
          if (commitWindow) begin
            state_q <= lastPop ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (lastPop) begin
            state_q <= ST_IDLE;
          end else if (!commitWindow) begin
            state_q <= ST_WAIT;
          end else if (fifoEmpty && !pushEn) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Live display registers, updated from the popped head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sprX_q     <= '0;
      sprY_q     <= '0;
      sprAttr_q  <= '0;
      sprVis_q   <= '0;
      bgColor_q  <= '0;
      fontWe_q   <= 1'b0;
      fontAddr_q <= '0;
      fontData_q <= '0;
    end else begin
      fontWe_q <= 1'b0;
      if (popEn) begin
        unique case (headEntry.cls)
          CMD_SPRITE: begin
            if (headEntry.selPos) begin
              sprX_q[int'(sprIdx)*COORD_W +: COORD_W] <= headEntry.srcbLo[COORD_W-1:0];
              sprY_q[int'(sprIdx)*COORD_W +: COORD_W] <= headEntry.srcbHi;
            end
            if (headEntry.selAttr) begin
              sprAttr_q[int'(sprIdx)*ATTR_W +: ATTR_W] <= headEntry.srcbLo;
            end
            if (headEntry.selVisi) begin
              sprVis_q[sprIdx] <= headEntry.srcbLo[0];
            end
          end
          CMD_FONT: begin
            fontWe_q   <= 1'b1;
            fontAddr_q <= headEntry.srca[FONT_ADDR_W-1:0];
            fontData_q <= headEntry.srcbLo[FONT_DATA_W-1:0];
          end
          CMD_BG: begin
            bgColor_q <= headEntry.srcbLo[COLOR_W-1:0];
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign spr_x        = sprX_q;
  assign spr_y        = sprY_q;
  assign spr_attr     = sprAttr_q;
  assign spr_vis      = sprVis_q;
  assign bg_color     = bgColor_q;
  assign font_we      = fontWe_q;
  assign font_addr    = fontAddr_q;
  assign font_data    = fontData_q;
  assign frame_commit = frameCommit_q;

endmodule

// File: tb/tb_vga_cmd_sink.sv
// Testbench for vga_cmd_sink: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// queue-based model of the command sink.
module tb_vga_cmd_sink;

  localparam int NS    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spriteE = 1'b0, fontE = 1'b0, backgroundE = 1'b0;
  logic        posE = 1'b0, attrE = 1'b0, visiE = 1'b0;
  logic        stallE = 1'b0;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic        vblank = 1'b0;

  logic              vga_stall;
  logic [NS*10-1:0]  spr_x, spr_y;
  logic [NS*16-1:0]  spr_attr;
  logic [NS-1:0]     spr_vis;
  logic [11:0]       bg_color;
  logic              font_we;
  logic [11:0]       font_addr;
  logic [7:0]        font_data;
  logic              frame_commit;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkOn = 1'b0;

  always #5 clk = ~clk;

  vga_cmd_sink #(.NSPRITE(NS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .spriteE(spriteE), .fontE(fontE), .backgroundE(backgroundE),
    .posE(posE), .attrE(attrE), .visiE(visiE), .stallE(stallE),
    .srcaE(srcaE), .srcbE(srcbE), .vblank(vblank),
    .vga_stall(vga_stall), .spr_x(spr_x), .spr_y(spr_y),
    .spr_attr(spr_attr), .spr_vis(spr_vis), .bg_color(bg_color),
    .font_we(font_we), .font_addr(font_addr), .font_data(font_data),
    .frame_commit(frame_commit)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int cls;   // 1 sprite, 2 font, 3 background
    bit pos, attr, visi;
    int srca;
    int srcb;
  } cmd_t;

  cmd_t q[$];
  int   mX[NS], mY[NS], mAttr[NS];
  bit   mVis[NS];
  int   mBg, mFontAddr, mFontData;
  bit   mFontWe, mFrame;

  function automatic void modelClear();
    q.delete();
    for (int i = 0; i < NS; i++) begin
      mX[i] = 0; mY[i] = 0; mAttr[i] = 0; mVis[i] = 1'b0;
    end
    mBg = 0; mFontAddr = 0; mFontData = 0; mFontWe = 1'b0; mFrame = 1'b0;
  endfunction

  function automatic void modelApply(cmd_t c);
    int i;
    i = c.srca % NS;
    if (c.cls == 1) begin
      if (c.pos) begin
        mX[i] = c.srcb & 32'h3FF;
        mY[i] = (c.srcb >> 16) & 32'h3FF;
      end
      if (c.attr) mAttr[i] = c.srcb & 32'hFFFF;
      if (c.visi) mVis[i] = c.srcb[0];
    end else if (c.cls == 2) begin
      mFontWe   = 1'b1;
      mFontAddr = c.srca & 32'hFFF;
      mFontData = c.srcb & 32'hFF;
    end else begin
      mBg = c.srcb & 32'hFFF;
    end
  endfunction

  // Each edge: commit the oldest entry if the window is open, then accept
  // the incoming command if there was room before the edge.
  always @(posedge clk) begin
    cmd_t c;
    int   sz;
    bit   win, doPop, doPush;
    if (reset) begin
      modelClear();
    end else begin
      sz = q.size();
`ifdef VGA_TEAR_GUARD_EN
      win = vblank;
`else
      win = 1'b1;
`endif
      doPop  = win && (sz > 0);
      doPush = (spriteE || fontE || backgroundE) && !stallE && (sz < DEPTH);
      mFontWe = 1'b0;
      mFrame  = doPop && (sz == 1) && !doPush;
      if (doPop) begin
        c = q.pop_front();
        modelApply(c);
      end
      if (doPush) begin
        c.cls  = spriteE ? 1 : (fontE ? 2 : 3);
        c.pos  = posE; c.attr = attrE; c.visi = visiE;
        c.srca = int'(srcaE); c.srcb = int'(srcbE);
        q.push_back(c);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NS*10-1:0] ex, ey;
    logic [NS*16-1:0] ea;
    logic [NS-1:0]    ev;
    if (checkOn) begin
      for (int i = 0; i < NS; i++) begin
        ex[i*10 +: 10] = mX[i][9:0];
        ey[i*10 +: 10] = mY[i][9:0];
        ea[i*16 +: 16] = mAttr[i][15:0];
        ev[i]          = mVis[i];
      end
      checkOutput("model spr_x", spr_x, ex);
      checkOutput("model spr_y", spr_y, ey);
      checkOutput("model spr_attr", spr_attr, ea);
      checkOutput("model spr_vis", spr_vis, ev);
      checkOutput("model bg_color", bg_color, mBg[11:0]);
      checkOutput("model font_we", font_we, mFontWe);
      checkOutput("model font_addr", font_addr, mFontAddr[11:0]);
      checkOutput("model font_data", font_data, mFontData[7:0]);
      checkOutput("model frame_commit", frame_commit, mFrame);
      checkOutput("model vga_stall", vga_stall, q.size() == DEPTH);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drives one cycle of inputs (set at a falling edge) and returns at the
  // next falling edge, after the rising edge has sampled them.
  task automatic applyStimulus(input logic spr, input logic fnt, input logic bg,
                               input logic pos, input logic att, input logic vis,
                               input logic stl, input logic [31:0] a,
                               input logic [31:0] b, input logic vbl);
    spriteE = spr; fontE = fnt; backgroundE = bg;
    posE = pos; attrE = att; visiE = vis; stallE = stl;
    srcaE = a; srcbE = b; vblank = vbl;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic vbl);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, '0, '0, vbl);
  endtask

  task automatic pushSprite(input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic vbl);
    applyStimulus(1, 0, 0, sel[2], sel[1], sel[0], 0, a, b, vbl);
  endtask

  task automatic pushBg(input logic [31:0] b, input logic vbl);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0, b, vbl);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit vb;
    int vbLeft;
    int r, cls;
    @(negedge clk);
    reset = 1'b1;
    idleCycles(2, 1'b0);
    reset = 1'b0;
    checkOn = 1'b1;

    checkOutput("reset spr_x", spr_x, '0);
    checkOutput("reset bg_color", bg_color, '0);
    checkOutput("reset vga_stall", vga_stall, 1'b0);
    checkOutput("reset frame_commit", frame_commit, 1'b0);

    // Sprite position commit: x = 200, y = 100 on sprite 3.
    pushSprite(3'b100, 32'd3, 32'h0064_00C8, 1'b0);
`ifdef VGA_TEAR_GUARD_EN
    idleCycles(2, 1'b0);
    checkOutput("gated spr_x3", spr_x[30 +: 10], 10'd0);
`endif
    idleCycles(1, 1'b1);
    checkOutput("sprite x3", spr_x[30 +: 10], 10'd200);
    checkOutput("sprite y3", spr_y[30 +: 10], 10'd100);
    checkOutput("sprite frame_commit", frame_commit, 1'b1);
    idleCycles(1, 1'b1);
    checkOutput("frame_commit single", frame_commit, 1'b0);

`ifdef VGA_TEAR_GUARD_EN
    // Full back-pressure: four entries fill the queue, extra strobes drop.
    for (int k = 1; k <= 4; k++) pushBg(k, 1'b0);
    checkOutput("full stall", vga_stall, 1'b1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, '0, 32'hBAD, 1'b0);
    checkOutput("full stallE held", vga_stall, 1'b1);
    pushBg(32'hDEF, 1'b0);
    idleCycles(1, 1'b1);
    checkOutput("full first pop bg", bg_color, 12'h001);
    checkOutput("full stall drops", vga_stall, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("full last bg", bg_color, 12'h004);
    idleCycles(1, 1'b1);
`endif

    // Background writes with vblank dropping after one commit.
    pushBg(32'h00F, 1'b0);
    pushBg(32'h0F0, 1'b0);
    pushBg(32'hF00, 1'b0);
`ifdef VGA_TEAR_GUARD_EN
    idleCycles(1, 1'b1);
    checkOutput("partial drain bg", bg_color, 12'h00F);
    idleCycles(2, 1'b0);
    checkOutput("held bg", bg_color, 12'h00F);
`endif
    idleCycles(3, 1'b1);
    checkOutput("resumed bg", bg_color, 12'hF00);

    // Font write strobe.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h123, 32'hA5, 1'b1);
    idleCycles(1, 1'b1);
    checkOutput("font_we high", font_we, 1'b1);
    checkOutput("font_addr", font_addr, 12'h123);
    checkOutput("font_data", font_data, 8'hA5);
    idleCycles(1, 1'b1);
    checkOutput("font_we one cycle", font_we, 1'b0);

    // Combined attr+visi sprite pushed while another entry pops.
    pushBg(32'h0AA, 1'b0);
    pushBg(32'h0BB, 1'b0);
    pushSprite(3'b011, 32'd5, 32'h8001, 1'b1);
    idleCycles(3, 1'b1);
    checkOutput("combined attr5", spr_attr[80 +: 16], 16'h8001);
    checkOutput("combined vis5", spr_vis[5], 1'b1);

    // Reset while entries are still queued.
    pushBg(32'h111, 1'b0);
    pushBg(32'h222, 1'b0);
    pushBg(32'h333, 1'b0);
`ifdef VGA_TEAR_GUARD_EN
    idleCycles(1, 1'b1);
    checkOutput("pre-reset bg", bg_color, 12'h111);
`endif
    reset = 1'b1;
    idleCycles(1, 1'b1);
    reset = 1'b0;
    checkOutput("mid reset bg", bg_color, 12'h000);
    checkOutput("mid reset attr", spr_attr, '0);
    idleCycles(4, 1'b1);
    checkOutput("post reset bg", bg_color, 12'h000);
    checkOutput("post reset frame", frame_commit, 1'b0);

    // Randomized traffic with vblank bursts and occasional resets.
    vb = 1'b0;
    vbLeft = 0;
    for (int c = 0; c < 2500; c++) begin
      if (vbLeft == 0) begin
        vb = ~vb;
        vbLeft = $urandom_range(1, 12);
      end
      vbLeft--;
      r   = $urandom_range(0, 99);
      cls = $urandom_range(0, 3);
      reset = ($urandom_range(0, 399) == 0);
      applyStimulus((r < 60) && (cls == 1), (r < 60) && (cls == 2), (r < 60) && (cls == 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), $urandom, $urandom, vb);
      reset = 1'b0;
    end

    checkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
